// File: rtl/pipo_load_arbiter_if.sv
// Request/grant and PIPO-register bundle between requesters, the load arbiter and the register.
// The master side is the requesters plus the register readback; the slave side is the arbiter.
interface pipo_load_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  urgent;
    logic                  err_clr;
    logic                  reg_enable;
    logic [WIDTH-1:0]      reg_parallel_in;
    logic [WIDTH-1:0]      reg_parallel_out;
    logic [IW-1:0]         owner;
    logic                  owner_valid;
    logic                  busy;
    logic                  load_err;

    modport master (
        output req_valid, req_data, urgent, err_clr, reg_parallel_out,
        input  req_ready, reg_enable, reg_parallel_in, owner, owner_valid, busy, load_err
    );

    modport slave (
        input  req_valid, req_data, urgent, err_clr, reg_parallel_out,
        output req_ready, reg_enable, reg_parallel_in, owner, owner_valid, busy, load_err
    );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin load sequencer for one shared PIPO register: grant, load, verify readback, hold.
// One load per 3+HOLD_CYCLES cycles; PIPO_ARB_URGENT_EN adds a requester-0 urgent override.
module pipo_load_arbiter #(
    parameter int WIDTH       = 8,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pipo_load_arbiter_if.slave     bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

    typedef logic [IW-1:0]   idx_t;
    typedef logic [IW:0]     cand_t;
    typedef logic [NREQ-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, HOLD} state_t;

    state_t           state_q, state_d;
    idx_t             ptr_q, ptr_d;
    idx_t             win_q, win_d;
    idx_t             owner_q, owner_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             urg_q, urg_d;
    logic             owner_vld_q, owner_vld_d;
    logic             err_q, err_d;

    logic             pick_found;
    logic             pick_urg;
    idx_t             pick_idx;
    logic [WIDTH-1:0] pick_dat;
    cand_t            cand;

    // First valid requester at or after the pointer, wrapping past NREQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_urg   = 1'b0;
        pick_idx   = '0;
        pick_dat   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = cand_t'(ptr_q) + cand_t'(i);
            if (cand >= cand_t'(NREQ)) cand = cand - cand_t'(NREQ);
            if (!pick_found && bus.req_valid[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
                pick_dat   = bus.req_data[int'(cand[IW-1:0])*WIDTH +: WIDTH];
            end
        end
`ifdef PIPO_ARB_URGENT_EN
        if (bus.urgent && bus.req_valid[0]) begin
            pick_found = 1'b1;
            pick_urg   = 1'b1;
            pick_idx   = '0;
            pick_dat   = bus.req_data[WIDTH-1:0];
        end
`endif
    end

`ifndef PIPO_ARB_URGENT_EN
    logic unused_urgent;
    assign unused_urgent = bus.urgent;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        urg_d       = urg_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        err_d       = err_q;
        if (bus.err_clr) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    data_d  = pick_dat;
                    urg_d   = pick_urg;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // An urgent grant leaves the rotation where it was.
                if (!urg_q) ptr_d = (win_q == idx_t'(NREQ - 1)) ? '0 : win_q + idx_t'(1);
                state_d = VERIFY;
            end
            VERIFY: begin
                if (bus.reg_parallel_out != data_q) err_d = 1'b1;
                owner_d     = win_q;
                owner_vld_d = 1'b1;
                cnt_d       = '0;
                state_d     = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = IDLE;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            owner_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            urg_q       <= 1'b0;
            owner_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            urg_q       <= urg_d;
            owner_vld_q <= owner_vld_d;
            err_q       <= err_d;
        end
    end

    assign bus.reg_enable      = (state_q == LOAD);
    assign bus.req_ready       = (state_q == LOAD) ? (vec_t'(1) << win_q) : '0;
    assign bus.reg_parallel_in = data_q;
    assign bus.owner           = owner_q;
    assign bus.owner_valid     = owner_vld_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.load_err        = err_q;
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench: main arbiter (HOLD_CYCLES=1) and a HOLD_CYCLES=0 instance, each with a PIPO model.
module tb_pipo_load_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic force_zero;
    logic [7:0] pipo_q, pipo0_q;

    int checks   = 0;
    int failures = 0;
    int ng, last, pend, found;
    logic [7:0] pend_val;
    logic [7:0] dv [4];
    int exp_idx [5];
    int g0_cyc [3];
    logic [3:0] g0_vec [3];

    always #5 clk = ~clk;

    pipo_load_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();
    pipo_load_arbiter_if #(.WIDTH(8), .NREQ(4)) bus0 ();

    pipo_load_arbiter #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    pipo_load_arbiter #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    always @(posedge clk) if (bus.reg_enable)  pipo_q  <= bus.reg_parallel_in;
    always @(posedge clk) if (bus0.reg_enable) pipo0_q <= bus0.reg_parallel_in;
    assign bus.reg_parallel_out  = force_zero ? 8'h00 : pipo_q;
    assign bus0.reg_parallel_out = pipo0_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d);
        bus.req_valid[i]        = v;
        bus.req_data[i*8 +: 8]  = d;
    endtask

    // Starts just after a negedge with the DUT idle; ends idle again four cycles later.
    task automatic single_load(input string tag, input int idx, input logic [7:0] d,
                               input logic [7:0] rb);
        set_req(idx, 1'b1, d);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(1) << idx);
        chk({tag, "_en"},  32'(bus.reg_enable), 32'd1);
        chk({tag, "_pin"}, 32'(bus.reg_parallel_in), 32'(d));
        set_req(idx, 1'b0, d);
        @(negedge clk);
        chk({tag, "_rdy_off"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_en_off"},  32'(bus.reg_enable), 32'd0);
        @(negedge clk);
        chk({tag, "_owner"}, 32'(bus.owner), 32'(idx));
        chk({tag, "_ovld"},  32'(bus.owner_valid), 32'd1);
        chk({tag, "_pout"},  32'(bus.reg_parallel_out), 32'(rb));
        @(negedge clk);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        dv      = '{8'h01, 8'h0A, 8'hFF, 8'h0C};
        exp_idx = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        force_zero = 1'b0;
        bus.req_valid = '0;  bus.req_data = '0;  bus.urgent = 1'b0;  bus.err_clr = 1'b0;
        bus0.req_valid = '0; bus0.req_data = '0; bus0.urgent = 1'b0; bus0.err_clr = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdy",  32'(bus.req_ready), 32'd0);
        chk("rst_en",   32'(bus.reg_enable), 32'd0);
        chk("rst_pin",  32'(bus.reg_parallel_in), 32'd0);
        chk("rst_own",  32'(bus.owner), 32'd0);
        chk("rst_ovld", 32'(bus.owner_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err",  32'(bus.load_err), 32'd0);
        reset = 1'b0;

        single_load("single", 2, 8'hA5, 8'hA5);
        chk("single_err", 32'(bus.load_err), 32'd0);
        // Pointer now 3; requester 0 alone must still win.
        single_load("wrap", 0, 8'h3C, 8'h3C);

        force_zero = 1'b1;
        single_load("mm1", 1, 8'hAA, 8'h00);
        chk("mm1_err", 32'(bus.load_err), 32'd1);
        @(negedge clk);
        chk("mm1_sticky", 32'(bus.load_err), 32'd1);
        set_req(1, 1'b1, 8'h55);
        @(negedge clk);
        chk("mm2_rdy", 32'(bus.req_ready), 32'b0010);
        set_req(1, 1'b0, 8'h55);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("mm2_set_wins", 32'(bus.load_err), 32'd1);
        force_zero = 1'b0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", 32'(bus.load_err), 32'd0);

        set_req(1, 1'b1, 8'h77);
        @(negedge clk);
        chk("rl_rdy", 32'(bus.req_ready), 32'b0010);
        #2 reset = 1'b1;
        #1;
        chk("rl_en_async",  32'(bus.reg_enable), 32'd0);
        chk("rl_rdy_async", 32'(bus.req_ready), 32'd0);
        chk("rl_ovld",      32'(bus.owner_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, dv[i]);
        ng = 0; last = 0; pend = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (pend != 0) begin
                chk("rr_pout", 32'(bus.reg_parallel_out), 32'(pend_val));
                pend = 0;
            end
            if (bus.req_ready != 4'd0 && ng < 5) begin
                chk("rr_grant", 32'(bus.req_ready), 32'(1) << exp_idx[ng]);
                if (ng > 0) chk("rr_spacing", 32'(c - last), 32'd4);
                chk("rr_pin", 32'(bus.reg_parallel_in), 32'(dv[exp_idx[ng]]));
                pend = 1; pend_val = dv[exp_idx[ng]]; last = c; ng++;
            end
        end
        chk("rr_count", 32'(ng), 32'd5);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        bus0.req_valid[3] = 1'b1; bus0.req_data[31:24] = 8'h33;
        ng = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) chk("h0_pout", 32'(bus0.reg_parallel_out), 32'h44);
            if (bus0.req_ready != 4'd0 && ng < 3) begin
                g0_cyc[ng] = c; g0_vec[ng] = bus0.req_ready; ng++;
            end
            if (c == 1) begin
                bus0.req_valid = 4'b0001; bus0.req_data[7:0] = 8'h44;
            end
        end
        bus0.req_valid = '0;
        chk("h0_count", 32'(ng), 32'd3);
        chk("h0_g0", 32'(g0_vec[0]), 32'b1000);
        chk("h0_g1", 32'(g0_vec[1]), 32'b0001);
        chk("h0_g2", 32'(g0_vec[2]), 32'b0001);
        chk("h0_c1", 32'(g0_cyc[1]), 32'd4);
        chk("h0_c2", 32'(g0_cyc[2] - g0_cyc[1]), 32'd3);
        repeat (3) @(negedge clk);

`ifdef PIPO_ARB_URGENT_EN
        single_load("ptr2", 1, 8'h11, 8'h11);
        set_req(0, 1'b1, 8'h5A);
        set_req(2, 1'b1, 8'h6B);
        bus.urgent = 1'b1;
        @(negedge clk);
        chk("urg_first", 32'(bus.req_ready), 32'b0001);
        chk("urg_pin",   32'(bus.reg_parallel_in), 32'h5A);
        set_req(0, 1'b0, 8'h5A);
        bus.urgent = 1'b0;
        found = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.req_ready != 4'd0 && found == 0) begin
                chk("urg_second", 32'(bus.req_ready), 32'b0100);
                set_req(2, 1'b0, 8'h6B);
                found = 1;
            end
        end
        chk("urg_second_seen", 32'(found), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and load sequencer that shares one 8-bit parallel-in/parallel-out register among several requesters. It sits directly in front of the PIPO register and drives its `enable` and `parallel_in`. It reads back `parallel_out` to confirm each load, and reports which requester owns the current register contents.

## Interface
- `WIDTH`, 8, data width; must equal the PIPO register width.
- `NREQ`, 4, number of requesters, 2..8.
- `HOLD_CYCLES`, 1, idle cycles enforced after each load, 0..15.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester load request.
- `req_data`  in  NREQ*WIDTH  requester i data at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot grant/acknowledge pulse.
- `urgent`  in  1  priority request for requester 0; used only when the urgent macro is defined.
- `err_clr`  in  1  clears `load_err`.
- `reg_enable`  out  1  drives PIPO `enable`.
- `reg_parallel_in`  out  WIDTH  drives PIPO `parallel_in`.
- `reg_parallel_out`  in  WIDTH  readback from PIPO `parallel_out`.
- `owner`  out  clog2(NREQ)  index of the requester whose data was last loaded.
- `owner_valid`  out  1  high once any load has completed.
- `busy`  out  1  high in any state other than IDLE.
- `load_err`  out  1  sticky flag for a readback mismatch.

## Operation
- **Reset values:** all outputs are 0 and the round-robin pointer is 0.
- **FSM states:** IDLE, LOAD, VERIFY, HOLD. All outputs are registered or decoded from state only.
- **IDLE:**
  - If any `req_valid` bit is set, pick the winner: the first set bit at or after the pointer, searching upward with wrap.
  - Latch the winner's `req_data` into the data register and go to LOAD.
  - If no bit is set, stay in IDLE.
- **LOAD (exactly 1 cycle):**
  - `reg_enable`=1.
  - `reg_parallel_in` = latched data.
  - `req_ready[winner]`=1.
  - Pointer becomes (winner+1) mod NREQ.
  - Next state is VERIFY.
- **VERIFY (1 cycle):**
  - Compare `reg_parallel_out` with the latched data.
  - On a mismatch, set `load_err`.
  - Set `owner`=winner and `owner_valid`=1.
  - Go to HOLD, or directly to IDLE if HOLD_CYCLES=0.
- **HOLD:** count HOLD_CYCLES cycles, then go to IDLE.
- `reg_parallel_in` keeps the last latched data outside LOAD. `reg_enable` is 0 outside LOAD.
- **Handshake:**
  - A requester holds `req_valid` and `req_data` until its `req_ready` pulse, then may change both.
  - If `req_valid` drops before the grant after the winner has been latched, the load still completes.
- `err_clr` clears `load_err`. If a mismatch and `err_clr` occur in the same cycle, set wins.

## Timing
- **Latency:** `req_valid` sampled at edge k in IDLE gives LOAD in cycle k..k+1. The PIPO captures at edge k+1 and the compare happens at edge k+2.
- **Throughput:** one load per 3+HOLD_CYCLES cycles under continuous requests.
- **All requesters valid:** grants follow 0,1,…,NREQ-1,0,… with no requester skipped.
- **Wrap-around:** with the pointer at NREQ-1 and only requester 0 valid, requester 0 wins.
- **Reset mid-operation (any state):**
  - `reg_enable` and `req_ready` drop immediately (asynchronous).
  - The FSM returns to IDLE, the pointer to 0, and `owner_valid` and `load_err` to 0.

## Configuration
- **`PIPO_ARB_URGENT_EN` defined:**
  - In IDLE, `urgent`=1 together with `req_valid[0]`=1 grants requester 0 regardless of the pointer.
  - An urgent grant does not update the pointer.
- **`PIPO_ARB_URGENT_EN` undefined:** the `urgent` port exists but is ignored, and arbitration is pure round-robin.

## Test plan
- **Single request.** Stimulus: after reset, requester 2 valid with data 8'hA5. Response: `req_ready`=4'b0100 for exactly 1 cycle, `reg_enable` high for the same cycle, `owner`=2, `owner_valid`=1, `load_err`=0, PIPO output 8'hA5.
- **All requesters, default parameters.** Stimulus: all 4 valid continuously with data 8'h01/8'h0A/8'hFF/8'h0C. Response: grants 0,1,2,3,0 spaced 4 cycles apart, each value appearing on the PIPO output in that order.
- **Readback mismatch.** Stimulus: force `reg_parallel_out` to 8'h00 while loading 8'hAA. Response: `load_err`=1, which stays set until `err_clr`; `err_clr` asserted in a later mismatch cycle leaves it at 1.
- **Reset during LOAD.** Stimulus: assert `reset` while in LOAD with requester 1 granted. Response: `reg_enable`=0 and `req_ready`=0 without waiting for a clock edge; after release, requester 0 wins first when all requesters are valid.
- **HOLD_CYCLES=0 with wrap.** Stimulus: pointer at 3, only requester 0 valid. Response: requester 0 granted; back-to-back loads 3 cycles apart.
- **Urgent override (macro defined).** Stimulus: pointer at 2, requesters 0 and 2 valid, `urgent`=1. Response: requester 0 granted first, then requester 2 granted next, since the pointer was unchanged.
